// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel button front end. Each raw pin is optionally
// inverted, synchronised through two flops, debounced with a stability
// counter, and turned into a clean level, a one-cycle press pulse and a
// long-press flag. Channels share nothing but the clock and reset.
module btn_conditioner #(
   parameter int N_BTN       = 5,
   parameter int DEB_CYCLES  = 500000,
   parameter int HOLD_CYCLES = 100000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic [N_BTN-1:0] btn_held
);

   // Debounce counter only needs to reach DEB_CYCLES-1; hold counter must
   // hold HOLD_CYCLES itself so it can saturate there.
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

   logic [N_BTN-1:0] w_in;
   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;

   // Bring every pin to active-high before it enters the synchroniser.
   always_comb begin
      w_in = btn_raw;
      if (ACTIVE_LOW) begin
         w_in = ~btn_raw;
      end else begin
         w_in = btn_raw;
      end
   end

   // Two-flop synchroniser for all channels.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= {N_BTN{1'b0}};
         r_sync2 <= {N_BTN{1'b0}};
      end else begin
         r_sync1 <= w_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic [DW-1:0] r_deb_cnt;
      logic [DW-1:0] w_deb_nxt;
      logic [HW-1:0] r_hold_cnt;
      logic [HW-1:0] w_hold_nxt;
      logic          r_stable;
      logic          w_stable_nxt;
      logic          r_pulse;
      logic          r_held;

      // Stability counter: a level change is accepted only after the
      // synchronised input has disagreed for DEB_CYCLES edges in a row.
      always_comb begin
         w_stable_nxt = r_stable;
         w_deb_nxt    = {DW{1'b0}};
         if (r_sync2[g] == r_stable) begin
            w_deb_nxt = {DW{1'b0}};
         end else if (r_deb_cnt == DEB_LAST) begin
            w_stable_nxt = r_sync2[g];
            w_deb_nxt    = {DW{1'b0}};
         end else begin
            w_deb_nxt = r_deb_cnt + DW'(1'b1);
         end
      end

      // Hold counter counts edges spent pressed and saturates, never wraps.
      always_comb begin
         w_hold_nxt = {HW{1'b0}};
         if (r_stable) begin
            if (r_hold_cnt == HOLD_MAX) begin
               w_hold_nxt = HOLD_MAX;
            end else begin
               w_hold_nxt = r_hold_cnt + HW'(1'b1);
            end
         end else begin
            w_hold_nxt = {HW{1'b0}};
         end
      end

      // Channel state; pulse and held look at the next level so that they
      // line up with the edge on which btn_level itself changes.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_deb_cnt  <= {DW{1'b0}};
            r_stable   <= 1'b0;
            r_pulse    <= 1'b0;
            r_hold_cnt <= {HW{1'b0}};
            r_held     <= 1'b0;
         end else begin
            r_deb_cnt  <= w_deb_nxt;
            r_stable   <= w_stable_nxt;
            r_pulse    <= w_stable_nxt & ~r_stable;
            r_hold_cnt <= w_hold_nxt;
            r_held     <= w_stable_nxt & (w_hold_nxt == HOLD_MAX);
         end
      end

      assign btn_level[g] = r_stable;
      assign btn_pulse[g] = r_pulse;
      assign btn_held[g]  = r_held;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random pin activity,
// every cycle compared against a window/timestamp reference model.
module tb_btn_conditioner;

   localparam int N    = 5;
   localparam int DEB  = 4;
   localparam int HOLD = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_raw = '1;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_pulse;
   logic [N-1:0] btn_held;

   btn_conditioner #(
      .N_BTN      (N),
      .DEB_CYCLES (DEB),
      .HOLD_CYCLES(HOLD),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .btn_held (btn_held)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: active-high input history, sync2 window, timestamps.
   logic [N-1:0] inp_q[$];
   logic [N-1:0] s2_q[$];
   logic [N-1:0] m_stable;
   logic [N-1:0] m_pulse;
   int           rise_n[N];
   int           n_edge;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] m_held();
      logic [N-1:0] h;
      h = '0;
      for (int c = 0; c < N; c++)
         h[c] = m_stable[c] && ((n_edge - rise_n[c]) >= HOLD);
      return h;
   endfunction

   task automatic model_reset();
      m_stable = '0;
      m_pulse  = '0;
      inp_q    = {};
      s2_q     = {};
      inp_q.push_back('0);
      inp_q.push_back('0);
      for (int c = 0; c < N; c++) rise_n[c] = 0;
   endtask

   // One clock edge: the synchronised view lags the pin by two edges, and a
   // channel flips once its last DEB synchronised samples all disagree.
   task automatic model_edge(input logic [N-1:0] raw);
      logic [N-1:0] s2;
      logic         all_diff;
      s2 = inp_q[inp_q.size() - 2];
      inp_q.push_back(~raw);
      void'(inp_q.pop_front());
      s2_q.push_back(s2);
      if (s2_q.size() > DEB) void'(s2_q.pop_front());
      n_edge++;
      m_pulse = '0;
      if (s2_q.size() == DEB) begin
         for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
               if (s2_q[k][c] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_stable[c] = ~m_stable[c];
               if (m_stable[c]) begin
                  m_pulse[c] = 1'b1;
                  rise_n[c]  = n_edge;
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string where);
      chk({where, "_level"}, btn_level, m_stable);
      chk({where, "_pulse"}, btn_pulse, m_pulse);
      chk({where, "_held"},  btn_held,  m_held());
   endtask

   // Advance one edge, update the model, compare just after the edge.
   task automatic step(input string where);
      @(posedge clk);
      if (rst) model_edge(btn_raw);
      else     model_reset();
      #1;
      compare_all(where);
   endtask

   // Asynchronous reset mid-cycle, held for the given number of edges.
   task automatic do_reset(input int cycles, input string where);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      compare_all({where, "_async"});
      for (int i = 0; i < cycles; i++) step({where, "_inrst"});
      rst = 1'b1;
   endtask

   int lvl_rise, held_rise, lvl_fall, held_fall, pulses, p_first, p_second;
   logic seen;

   initial begin
      model_reset();
      n_edge = 0;
      #2;
      rst = 1'b0;
      #1;
      compare_all("rst0");
      for (int i = 0; i < 3; i++) step("rst");
      rst = 1'b1;

      // 1: clean press on channel 1
      btn_raw[1] = 1'b0;
      for (int i = 0; i < 5; i++) step("s1");
      chk("s1_before_k5", btn_level, 5'b00000);
      step("s1");
      chk("s1_level_k5", btn_level, 5'b00010);
      chk("s1_pulse_k5", btn_pulse, 5'b00010);
      step("s1");
      chk("s1_pulse_once", btn_pulse, 5'b00000);
      btn_raw[1] = 1'b1;
      for (int i = 0; i < 10; i++) step("s1r");

      // 2: bounce on channel 2 never gets through
      seen = 1'b0;
      for (int i = 0; i < 17; i++) begin
         btn_raw[2] = !((i < 3) || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
         step("s2");
         if (btn_level[2] || btn_pulse[2]) seen = 1'b1;
      end
      chk("s2_no_level", {31'd0, seen}, 32'd0);

      // 3: simultaneous press and release on channels 2 and 3
      btn_raw[3:2] = 2'b00;
      for (int i = 0; i < 6; i++) step("s3");
      chk("s3_pulse", btn_pulse, 5'b01100);
      for (int i = 0; i < 4; i++) step("s3");
      btn_raw[3:2] = 2'b11;
      for (int i = 0; i < 5; i++) step("s3r");
      chk("s3_level_before", btn_level, 5'b01100);
      step("s3r");
      chk("s3_level_after", btn_level, 5'b00000);
      chk("s3_no_rel_pulse", btn_pulse, 5'b00000);
      for (int i = 0; i < 4; i++) step("s3r");

      // 4: long press on channel 0
      lvl_rise = -1; held_rise = -1; lvl_fall = -1; held_fall = -1; pulses = 0;
      btn_raw[0] = 1'b0;
      for (int i = 0; i < 55; i++) begin
         if (i == 40) btn_raw[0] = 1'b1;
         step("s4");
         if (btn_pulse[0]) pulses++;
         if (btn_level[0] && lvl_rise < 0) lvl_rise = i;
         if (btn_held[0] && held_rise < 0) held_rise = i;
         if (!btn_level[0] && lvl_rise >= 0 && lvl_fall < 0) lvl_fall = i;
         if (!btn_held[0] && held_rise >= 0 && held_fall < 0) held_fall = i;
      end
      chk("s4_pulses", pulses, 1);
      chk("s4_lvl_rise", lvl_rise, 5);
      chk("s4_held_rise", held_rise, 21);
      chk("s4_lvl_fall", lvl_fall, 45);
      chk("s4_held_fall", held_fall, 45);

      // 5: reset while channel 4 is held down
      btn_raw[4] = 1'b0;
      for (int i = 0; i < 30; i++) step("s5");
      chk("s5_pre_level", btn_level, 5'b10000);
      chk("s5_pre_held", btn_held, 5'b10000);
      do_reset(2, "s5");
      pulses = 0; p_first = -1;
      for (int i = 0; i < 10; i++) begin
         step("s5p");
         if (btn_pulse[4]) begin
            pulses++;
            if (p_first < 0) p_first = i;
         end
      end
      chk("s5_pulse_count", pulses, 1);
      chk("s5_pulse_edge", p_first + 1, 6);
      btn_raw[4] = 1'b1;
      for (int i = 0; i < 10; i++) step("s5r");

      // 6: rapid re-press on channel 1
      pulses = 0; p_first = -1; p_second = -1;
      for (int i = 0; i < 32; i++) begin
         btn_raw[1] = ((i < 6) || (i >= 12 && i < 18)) ? 1'b0 : 1'b1;
         step("s6");
         if (btn_pulse[1]) begin
            pulses++;
            if (p_first < 0) p_first = i;
            else if (p_second < 0) p_second = i;
         end
      end
      chk("s6_pulses", pulses, 2);
      chk("s6_spacing", p_second - p_first, 12);

      // Random pin activity with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 11) == 0) btn_raw[c] = ~btn_raw[c];
         if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3), "rnd");
         else step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
